// File: rtl/pl_wb_regfile.sv
// Writeback stage: selects the W-stage result, commits it to the 32x32 integer register file,
// serves two bypassed decode read ports and emits a commit trace. Define RETIRE_CNT_EN for InstRetW.
module pl_wb_regfile #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] SP_INIT = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ValidW,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcW,
  input  logic [XLEN-1:0] ALUResultW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [XLEN-1:0] PCPlus4W,
  input  logic [XLEN-1:0] lAuiPCW,
  input  logic [4:0]      RdW,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
  output logic [XLEN-1:0] ResultW,
  output logic            CommitStrobe,
  output logic [4:0]      CommitRd,
  output logic [XLEN-1:0] CommitData,
  output logic [63:0]     InstRetW
);

  logic [XLEN-1:0] regs_q [32];
  logic            we;

  logic            commit_strobe_q, commit_strobe_d;
  logic [4:0]      commit_rd_q, commit_rd_d;
  logic [XLEN-1:0] commit_data_q, commit_data_d;

  function automatic logic [XLEN-1:0] select_result(
    input logic [1:0]      src,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] ld,
    input logic [XLEN-1:0] pc4,
    input logic [XLEN-1:0] upper
  );
    logic [XLEN-1:0] r;
    case (src)
      2'b00:   r = alu;
      2'b01:   r = ld;
      2'b10:   r = pc4;
      default: r = upper;
    endcase
    return r;
  endfunction

  // Write-through read: the W-stage value wins over the array in the same cycle.
  function automatic logic [XLEN-1:0] read_port(
    input logic [4:0]      addr,
    input logic            wr_en,
    input logic [4:0]      wr_addr,
    input logic [XLEN-1:0] wr_data,
    input logic [XLEN-1:0] arr_data
  );
    logic [XLEN-1:0] r;
    if (addr == 5'd0)                    r = '0;
    else if (wr_en && (addr == wr_addr)) r = wr_data;
    else                                 r = arr_data;
    return r;
  endfunction

  assign ResultW = select_result(ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, lAuiPCW);
  assign we      = RegWriteW & ValidW & (RdW != 5'd0);

  assign RD1D = read_port(Rs1D, we, RdW, ResultW, regs_q[Rs1D]);
  assign RD2D = read_port(Rs2D, we, RdW, ResultW, regs_q[Rs2D]);

  // regs_q[0] is reset to zero and never written, so x0 stays hardwired.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 2) ? SP_INIT : '0;
      end
    end else if (we) begin
      regs_q[RdW] <= ResultW;
    end
  end

  always_comb begin
    commit_strobe_d = we;
    commit_rd_d     = commit_rd_q;
    commit_data_d   = commit_data_q;
    if (we) begin
      commit_rd_d   = RdW;
      commit_data_d = ResultW;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_strobe_q <= 1'b0;
      commit_rd_q     <= '0;
      commit_data_q   <= '0;
    end else begin
      commit_strobe_q <= commit_strobe_d;
      commit_rd_q     <= commit_rd_d;
      commit_data_q   <= commit_data_d;
    end
  end

  assign CommitStrobe = commit_strobe_q;
  assign CommitRd     = commit_rd_q;
  assign CommitData   = commit_data_q;

`ifdef RETIRE_CNT_EN
  logic [63:0] instret_q, instret_d;

  // Every real W-stage slot retires, including stores and branches.
  assign instret_d = ValidW ? (instret_q + 64'd1) : instret_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) instret_q <= '0;
    else          instret_q <= instret_d;
  end

  assign InstRetW = instret_q;
`else
  assign InstRetW = '0;
`endif

endmodule

// File: tb/tb_pl_wb_regfile.sv
// Bench for pl_wb_regfile: vector table, directed corner sequences and a random run
// against an array-based reference model of the register file and commit trace.
module tb_pl_wb_regfile;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            ValidW, RegWriteW;
  logic [1:0]      ResultSrcW;
  logic [XLEN-1:0] ALUResultW, ReadDataW, PCPlus4W, lAuiPCW;
  logic [4:0]      RdW, Rs1D, Rs2D;
  logic [XLEN-1:0] RD1D, RD2D, ResultW, CommitData;
  logic            CommitStrobe;
  logic [4:0]      CommitRd;
  logic [63:0]     InstRetW;

  pl_wb_regfile #(.XLEN(XLEN), .SP_INIT(32'h0000_0100)) dut (
    .clk(clk), .reset_n(reset_n), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .lAuiPCW(lAuiPCW), .RdW(RdW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW), .CommitStrobe(CommitStrobe),
    .CommitRd(CommitRd), .CommitData(CommitData), .InstRetW(InstRetW)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [XLEN-1:0] m_regs [32];
  logic            m_strobe;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  logic [63:0]     m_ret;

  typedef struct {
    logic            valid, rw;
    logic [1:0]      src;
    logic [XLEN-1:0] alu, ld, pc4, up;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] exp_res, exp_rd1, exp_rd2;
    string           name;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] m_result();
    case (ResultSrcW)
      2'd0:    return ALUResultW;
      2'd1:    return ReadDataW;
      2'd2:    return PCPlus4W;
      default: return lAuiPCW;
    endcase
  endfunction

  function automatic logic m_we();
    return RegWriteW && ValidW && (RdW != 0);
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (m_we() && a == RdW) return m_result();
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_regs[2] = 32'h0000_0100;
    m_strobe = 1'b0; m_rd = '0; m_data = '0; m_ret = '0;
  endtask

  // Advance one clock edge, updating the model from the inputs held across it.
  task automatic tick();
    logic            we;
    logic [XLEN-1:0] res;
    we  = m_we();
    res = m_result();
    @(posedge clk);
    if (reset_n) begin
      if (we) begin
        m_regs[RdW] = res;
        m_rd = RdW;
        m_data = res;
      end
      m_strobe = we;
      if (ValidW) m_ret = m_ret + 64'd1;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ResultW"}, ResultW, m_result());
    chk({tag, ".RD1D"}, RD1D, m_read(Rs1D));
    chk({tag, ".RD2D"}, RD2D, m_read(Rs2D));
    chk({tag, ".CommitStrobe"}, CommitStrobe, m_strobe);
    chk({tag, ".CommitRd"}, CommitRd, m_rd);
    chk({tag, ".CommitData"}, CommitData, m_data);
`ifdef RETIRE_CNT_EN
    chk({tag, ".InstRetW"}, InstRetW, m_ret);
`else
    chk({tag, ".InstRetW"}, InstRetW, 64'd0);
`endif
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] s,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] l,
                       input logic [XLEN-1:0] p, input logic [XLEN-1:0] u,
                       input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2);
    ValidW = v; RegWriteW = w; ResultSrcW = s;
    ALUResultW = a; ReadDataW = l; PCPlus4W = p; lAuiPCW = u;
    RdW = d; Rs1D = r1; Rs2D = r2;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    m_reset();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    vecs[0] = '{1, 1, 2'd0, 32'h11, 32'h22, 32'h33, 32'h44, 5'd7, 5'd7, 5'd7, 32'h11, 32'h11, 32'h11, "sel_alu"};
    vecs[1] = '{1, 1, 2'd1, 32'h11, 32'h22, 32'h33, 32'h44, 5'd7, 5'd7, 5'd7, 32'h22, 32'h22, 32'h22, "sel_load"};
    vecs[2] = '{1, 1, 2'd2, 32'h11, 32'h22, 32'h33, 32'h44, 5'd7, 5'd7, 5'd7, 32'h33, 32'h33, 32'h33, "sel_pc4"};
    vecs[3] = '{1, 1, 2'd3, 32'h11, 32'h22, 32'h33, 32'h44, 5'd7, 5'd7, 5'd7, 32'h44, 32'h44, 32'h44, "sel_upper"};
    vecs[4] = '{1, 1, 2'd0, 32'hDEAD_BEEF, 0, 0, 0, 5'd10, 5'd10, 5'd10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "bypass"};
    vecs[5] = '{1, 1, 2'd0, 32'h99, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0, "x0_write"};
    vecs[6] = '{0, 1, 2'd0, 32'h77, 0, 0, 0, 5'd3, 5'd3, 5'd2, 32'h77, 32'h0, 32'h100, "bubble"};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 2, 5);
    reset_n = 1'b0;
    #1;
    m_reset();
    chk("reset.CommitStrobe", CommitStrobe, 0);
    chk("reset.CommitRd", CommitRd, 0);
    chk("reset.CommitData", CommitData, 0);
    chk("reset.InstRetW", InstRetW, 0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("reset.x2", RD1D, 32'h0000_0100);
    chk("reset.x5", RD2D, 32'h0);
    check_all("reset");

    // Vector table
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].valid, vecs[i].rw, vecs[i].src, vecs[i].alu, vecs[i].ld,
            vecs[i].pc4, vecs[i].up, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
      chk({vecs[i].name, ".ResultW"}, ResultW, vecs[i].exp_res);
      chk({vecs[i].name, ".RD1D"}, RD1D, vecs[i].exp_rd1);
      chk({vecs[i].name, ".RD2D"}, RD2D, vecs[i].exp_rd2);
      check_all(vecs[i].name);
      tick();
      if (i < 4) begin
        chk({vecs[i].name, ".commit_rd"}, CommitRd, 7);
        chk({vecs[i].name, ".commit_data"}, CommitData, vecs[i].exp_res);
      end
    end
    chk("bubble.no_strobe", CommitStrobe, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 3);
    chk("after.x7", RD1D, 32'h44);
    chk("after.x3", RD2D, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 10, 0);
    chk("after.x10", RD1D, 32'hDEAD_BEEF);
    chk("after.x0", RD2D, 32'h0);
    check_all("after");

    // Back-to-back writes to the same rd: last wins
    drive(1, 1, 0, 32'hA1, 0, 0, 0, 5'd9, 5'd9, 5'd9);
    tick();
    drive(1, 1, 0, 32'hB2, 0, 0, 0, 5'd9, 5'd9, 5'd9);
    chk("b2b.bypass", RD1D, 32'hB2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
    chk("b2b.x9", RD2D, 32'hB2);
    check_all("b2b");

    // Mid-cycle reset clears state and discards a pending write
    drive(1, 1, 0, 32'h55, 0, 0, 0, 5'd4, 5'd4, 5'd4);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 2);
    chk("midrst.x4_before", RD1D, 32'h55);
    chk("midrst.data_before", CommitData, 32'h55);
    reset_n = 1'b0;
    #1;
    m_reset();
    chk("midrst.x4", RD1D, 32'h0);
    chk("midrst.CommitData", CommitData, 32'h0);
    chk("midrst.CommitStrobe", CommitStrobe, 0);
    check_all("midrst");
    drive(1, 1, 0, 32'h66, 0, 0, 0, 5'd4, 5'd1, 5'd2);
    tick();
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 2);
    chk("midrst.pending_dropped", RD1D, 32'h0);
    chk("midrst.sp", RD2D, 32'h100);
    check_all("midrst_after");

    // Retire count: 5 valid, 2 bubbles, 3 valid
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive((i < 5 || i >= 7), i[0], 0, i, 0, 0, 0, 5'd12, 5'd0, 5'd0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef RETIRE_CNT_EN
    chk("retire.count", InstRetW, 64'd8);
`else
    chk("retire.count", InstRetW, 64'd0);
`endif
    check_all("retire");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rd;
      rd = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom, rd,
            ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)));
      check_all("rand");
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 32; a++) begin
      Rs1D = 5'(a);
      Rs2D = 5'(31 - a);
      #1;
      chk("final.RD1D", RD1D, m_read(Rs1D));
      chk("final.RD2D", RD2D, m_read(Rs2D));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pl_wb_regfile.md
Name: pl_wb_regfile

Overview:
- Consumer end of the memory|writeback pipeline register: takes W-stage control and data, selects the writeback result and commits it to the integer register file.
- Owns the 32x32 architectural register file (x0 hardwired to zero) and serves the decode stage's two combinational read ports with write-through bypass.
- Emits a registered commit trace (strobe, rd, data) for the bench and debug.
- Optionally counts retired instructions.

Parameters:
- XLEN, 32, datapath width.
- SP_INIT, 32'h0000_0100, reset value of x2 (sp).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ValidW  input  1  W-stage slot holds a real instruction (not a bubble).
- RegWriteW  input  1  write enable from W stage.
- ResultSrcW  input  2  result select.
- ALUResultW  input  XLEN  ALU result.
- ReadDataW  input  XLEN  load data.
- PCPlus4W  input  XLEN  link value.
- lAuiPCW  input  XLEN  lui/auipc value.
- RdW  input  5  destination register.
- Rs1D  input  5  decode read address 1.
- Rs2D  input  5  decode read address 2.
- RD1D  output  XLEN  read data 1.
- RD2D  output  XLEN  read data 2.
- ResultW  output  XLEN  selected writeback value, combinational, for EX forwarding.
- CommitStrobe  output  1  one-cycle pulse in the cycle after a register write.
- CommitRd  output  5  rd of the last write.
- CommitData  output  XLEN  data of the last write.
- InstRetW  output  64  retired-instruction count.

Behaviour:
- Reset (reset_n low, asynchronous assert, synchronous-to-clk deassert):
  - x1..x31 = 0, except x2 = SP_INIT.
  - CommitStrobe = 0, CommitRd = 0, CommitData = 0, InstRetW = 0.
  - Reset asserted mid-cycle clears all of these immediately.
  - A write pending in that cycle is discarded.
- Result select (combinational): ResultSrcW 00 = ALUResultW, 01 = ReadDataW, 10 = PCPlus4W, 11 = lAuiPCW.
- Write qualifier: we = RegWriteW & ValidW & (RdW != 0).
- Register write: on rising edge when we, regs[RdW] <= ResultW. Writes to x0 are dropped; x0 always reads 0.
- Read ports (combinational), for each port:
  - addr == 0 -> 0.
  - Else if we and addr == RdW -> ResultW (write-through bypass, zero added latency).
  - Else -> regs[addr].
- Both read ports may address the same register; both receive identical data, including the bypass case.
- Commit trace (registered, 1-cycle latency):
  - CommitStrobe <= we.
  - When we: CommitRd <= RdW and CommitData <= ResultW.
  - Otherwise CommitRd and CommitData hold their values.
- Bubbles: ValidW = 0 with RegWriteW = 1 performs no write, produces no strobe and is not counted.
- Back-to-back writes to the same rd: last write wins. The bypass always reflects the current W-stage value.
- Total latency: W-stage data is visible on the read ports the same cycle (bypass) and from the array every cycle after.

Optional Feature:
- Macro: RETIRE_CNT_EN.
- Defined:
  - InstRetW is a 64-bit counter, incremented by 1 on each rising edge with ValidW = 1, regardless of RegWriteW (stores and branches retire too).
  - Wraps from 2^64-1 to 0.
  - Cleared by reset.
- Undefined: no counter is built and InstRetW is tied to 0.

Test Plan:
- Reset check: deassert reset_n and read x2 and x5 -> RD1D = 32'h0000_0100, RD2D = 0; CommitStrobe = 0.
- Result select and commit: ValidW = 1, RegWriteW = 1, RdW = 7; cycle through ResultSrcW 00/01/10/11 with ALUResultW = 32'h11, ReadDataW = 32'h22, PCPlus4W = 32'h33, lAuiPCW = 32'h44 -> ResultW matches each value; x7 holds 32'h44 after the last edge; CommitRd = 7 and CommitData matches each value one cycle later.
- Bypass: RdW = 10, ResultW = 32'hDEAD_BEEF, Rs1D = Rs2D = 10 in the same cycle -> RD1D = RD2D = 32'hDEAD_BEEF before the edge.
- x0 and bubble: a write to RdW = 0, then ValidW = 0 with RegWriteW = 1 and RdW = 3 -> x0 reads 0, x3 is unchanged, no CommitStrobe.
- Mid-operation reset: after writing x4 = 32'h55, pulse reset_n low between clock edges -> x4 reads 0 immediately and CommitData = 0.
- RETIRE_CNT_EN defined: 5 valid cycles, 2 bubbles, 3 valid cycles -> InstRetW = 8. Macro undefined: InstRetW = 0.
